pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// RISC-Z fetch program counter: sequential increment, branch/call/return
// redirect, and a circular return-address stack with sticky over/underflow flags.
module pc_unit #(
  parameter int unsigned       WIDTH     = 10,
  parameter int unsigned       STEP      = 1,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_en,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned      PW     = $clog2(RAS_DEPTH);
  localparam int unsigned      CW     = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [CW-1:0]    FULL_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             push;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign pc_inc = pc_q + STEP_W;

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[ptr_q];
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        // When full, the pre-incremented pointer lands on the oldest entry.
        push  = 1'b1;
        ptr_d = ptr_q + PW'(1);
        pc_d  = call_target;
        if (cnt_q == FULL_C) ovf_d = 1'b1;
        else                 cnt_d = cnt_q + CW'(1);
      end else if (branch_en) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ras_q[ptr_d] <= pc_inc;
  end

  assign pc        = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_C);
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: default-parameter vector table plus a
// wide-PC / deep-RAS instance exercised by a hand-written call sequence.
module tb_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-parameter DUT
  logic       rst, stall, br, call, ret;
  logic [9:0] bt, ct, pc;
  logic       emp, full, ovf, unf;

  pc_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_en(br), .branch_target(bt),
    .call_en(call), .call_target(ct), .ret_en(ret),
    .pc(pc), .ras_empty(emp), .ras_full(full), .ras_ovf(ovf), .ras_unf(unf)
  );

  // wide DUT
  logic        rst2, stall2, br2, call2, ret2;
  logic [15:0] bt2, ct2, pc2;
  logic        emp2, full2, ovf2, unf2;

  pc_unit #(.WIDTH(16), .STEP(4), .RESET_VEC(16'h0100), .RAS_DEPTH(8)) u_dut2 (
    .clk(clk), .rst(rst2), .stall(stall2),
    .branch_en(br2), .branch_target(bt2),
    .call_en(call2), .call_target(ct2), .ret_en(ret2),
    .pc(pc2), .ras_empty(emp2), .ras_full(full2), .ras_ovf(ovf2), .ras_unf(unf2)
  );

  typedef struct {
    logic       rst, stall, br;
    logic [9:0] bt;
    logic       call;
    logic [9:0] ct;
    logic       ret;
    logic [9:0] exp_pc;
    logic [3:0] exp_flags; // {empty, full, ovf, unf}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic s, input logic b, input int t_b,
                             input logic c, input int t_c, input logic rt,
                             input int epc, input logic [3:0] ef);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.bt = 10'(t_b);
    x.call = c; x.ct = 10'(t_c); x.ret = rt;
    x.exp_pc = 10'(epc); x.exp_flags = ef;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            rst st br bt    call ct   ret  pc    flags
    vecs.push_back(v(1, 0, 0, 0,    0, 0,   0,   0,    4'b1000)); // 0 reset
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   1,    4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   2,    4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   3,    4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   4,    4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   5,    4'b1000));
    vecs.push_back(v(1, 0, 0, 0,    0, 0,   0,   0,    4'b1000)); // 6 reset at pc=5
    vecs.push_back(v(0, 0, 1, 1022, 0, 0,   0,   1022, 4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   1023, 4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   0,    4'b1000)); // 9 wrap
    vecs.push_back(v(0, 1, 1, 100,  0, 0,   0,   0,    4'b1000)); // stall drops branch
    vecs.push_back(v(0, 1, 1, 100,  0, 0,   0,   0,    4'b1000));
    vecs.push_back(v(0, 1, 1, 100,  0, 0,   0,   0,    4'b1000));
    vecs.push_back(v(0, 0, 1, 10,   0, 0,   0,   10,   4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    1, 200, 0,   200,  4'b0000)); // 14 call
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   201,  4'b0000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   202,  4'b0000));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   11,   4'b1000)); // 17 return
    vecs.push_back(v(0, 0, 1, 10,   0, 0,   0,   10,   4'b1000));
    vecs.push_back(v(0, 0, 0, 0,    1, 20,  0,   20,   4'b0000)); // 19 five calls
    vecs.push_back(v(0, 0, 0, 0,    1, 30,  0,   30,   4'b0000));
    vecs.push_back(v(0, 0, 0, 0,    1, 40,  0,   40,   4'b0000));
    vecs.push_back(v(0, 0, 0, 0,    1, 50,  0,   50,   4'b0100));
    vecs.push_back(v(0, 0, 0, 0,    1, 60,  0,   60,   4'b0110)); // 23 overflow
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   51,   4'b0010));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   41,   4'b0010));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   31,   4'b0010));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   21,   4'b1010));
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   22,   4'b1011)); // 28 underflow
    vecs.push_back(v(0, 0, 1, 76,   0, 0,   0,   76,   4'b1011));
    vecs.push_back(v(0, 0, 0, 0,    1, 300, 0,   300,  4'b0011)); // pushes 77
    vecs.push_back(v(0, 0, 1, 600,  1, 500, 1,   77,   4'b1011)); // 31 ret wins
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   78,   4'b1011)); // no push happened
    vecs.push_back(v(0, 0, 1, 900,  1, 400, 0,   400,  4'b0011)); // call beats branch
    vecs.push_back(v(0, 1, 0, 0,    0, 0,   1,   400,  4'b0011)); // stall holds RAS
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   1,   79,   4'b1011));
    vecs.push_back(v(1, 0, 1, 5,    1, 9,   1,   0,    4'b1000)); // 36 reset overrides
    vecs.push_back(v(0, 0, 0, 0,    0, 0,   0,   1,    4'b1000));

    rst = 1'b1; stall = 1'b0; br = 1'b0; call = 1'b0; ret = 1'b0; bt = '0; ct = '0;
    rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; call2 = 1'b0; ret2 = 1'b0; bt2 = '0; ct2 = '0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall; br = vecs[i].br; bt = vecs[i].bt;
      call = vecs[i].call; ct = vecs[i].ct; ret = vecs[i].ret;
      @(posedge clk); #1;
      chk("pc", i, 32'(pc), 32'(vecs[i].exp_pc));
      chk("flags", i, 32'({emp, full, ovf, unf}), 32'(vecs[i].exp_flags));
    end
    rst = 1'b1; br = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0;

    // wide instance
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("w_reset_pc", 0, 32'(pc2), 32'h0100);
    chk("w_reset_flags", 0, 32'({emp2, full2, ovf2, unf2}), 32'b1000);
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("w_step_pc", 0, 32'(pc2), 32'h0104);
    for (int i = 0; i < 9; i++) begin
      call2 = 1'b1; ct2 = 16'(32'h1000 + 16 * i);
      @(posedge clk); #1;
      chk("w_call_pc", i, 32'(pc2), 32'h1000 + 32'(16 * i));
      if (i == 7) chk("w_full_noovf", i, 32'({full2, ovf2}), 32'b10);
    end
    call2 = 1'b0;
    chk("w_ovf", 8, 32'({emp2, full2, ovf2, unf2}), 32'b0110);
    ret2 = 1'b1;
    @(posedge clk); #1;
    chk("w_ret_pc", 0, 32'(pc2), 32'h1074);
    chk("w_ret_flags", 0, 32'({emp2, full2, ovf2, unf2}), 32'b0010);
    ret2 = 1'b0;
    @(posedge clk); #1;
    chk("w_step_after_ret", 0, 32'(pc2), 32'h1078);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
